// File: rtl/jtkcpu_bus_pkg.sv
// Shared types for the jtkcpu bus bridge: FSM state encoding, the open-bus
// read value and a little-endian byte picker for 32-bit ROM words.
package jtkcpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROM_WAIT = 2'd1,
      RAM_RD   = 2'd2,
      ACK      = 2'd3
   } bus_state_t;

   localparam logic [7:0] OPEN_BUS = 8'hFF;

   function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/jtkcpu_bridge_ram.sv
// Single-port work RAM for the bus bridge. Registered read, write-first:
// on a write cycle the output register takes the new data.
module jtkcpu_bridge_ram #(
   parameter int RAM_AW = 13
) (
   input  logic              clk,
   input  logic [RAM_AW-1:0] addr,
   input  logic              we,
   input  logic [7:0]        din,
   output logic [7:0]        q
);

   logic [7:0] mem [2**RAM_AW];

   // write port plus registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
         q         <= din;
      end else begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/jtkcpu_busbridge.sv
// Bus bridge between the jtkcpu core and ROM (request/ok port), internal
// work RAM and an external I/O port. Reads of ROM/RAM stall the CPU via
// dtack until the byte is latched; repeated reads of the same address hit
// the served register with no wait.
// Optional build macro: JTKCPU_ROMLINE_EN adds a one-word ROM line buffer.
//
// state    | meaning
// IDLE     | waiting for a ROM/RAM read miss
// ROM_WAIT | rom_req high, waiting for rom_ok
// RAM_RD   | BRAM (or line buffer) output valid, latch it
// ACK      | result presented, dtack_r already high
module jtkcpu_busbridge
   import jtkcpu_bus_pkg::*;
#(
   parameter int ROM_AW = 20,
   parameter int RAM_AW = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_cen,
   input  logic [23:0]       cpu_addr,
   input  logic [7:0]        cpu_dout,
   input  logic              cpu_we,
   output logic [7:0]        cpu_din,
   output logic              cpu_dtack,
   input  logic              rom_cs,
   input  logic              ram_cs,
   input  logic              io_cs,
   output logic [ROM_AW-3:0] rom_addr,
   output logic              rom_req,
   input  logic              rom_ok,
   input  logic [31:0]       rom_data,
   input  logic [7:0]        io_din,
   output logic              io_we
);

   bus_state_t  state;
   logic [23:0] srv_addr;
   logic [23:0] req_addr;
   logic        srv_valid;
   logic        dtack_r;
   logic [7:0]  din_r;
   logic [7:0]  ram_q;
   logic        miss;
   logic        ram_we;
   logic        wr_srv;

   assign miss      = ~cpu_we & (rom_cs | ram_cs) & (~srv_valid | (cpu_addr != srv_addr));
   assign cpu_dtack = dtack_r & ~miss;
   assign ram_we    = cpu_cen & cpu_we & ram_cs;
   assign io_we     = cpu_cen & cpu_we & io_cs & ~rom_cs & ~ram_cs;
   assign wr_srv    = cpu_cen & cpu_we & (cpu_addr == srv_addr);

   // read data mux: ROM/RAM from the served latch, I/O passes straight through
   always_comb begin
      cpu_din = OPEN_BUS;
      if (rom_cs || ram_cs) begin
         cpu_din = din_r;
      end else if (io_cs) begin
         cpu_din = io_din;
      end
   end

   // the RAM address follows the CPU bus; the IDLE-cycle read lands in RAM_RD
   jtkcpu_bridge_ram #(.RAM_AW(RAM_AW)) u_ram (
      .clk  (clk),
      .addr (cpu_addr[RAM_AW-1:0]),
      .we   (ram_we),
      .din  (cpu_dout),
      .q    (ram_q)
   );

`ifdef JTKCPU_ROMLINE_EN
   logic              line_valid;
   logic [ROM_AW-3:0] line_tag;
   logic [31:0]       line_data;
   logic              use_line;
   logic              line_hit;

   assign line_hit = line_valid & (line_tag == cpu_addr[ROM_AW-1:2]);

   // keep the last full ROM word; only reset invalidates it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_valid <= 1'b0;
      end else if (state == ROM_WAIT && rom_ok) begin
         line_valid <= 1'b1;
         line_tag   <= req_addr[ROM_AW-1:2];
         line_data  <= rom_data;
      end
   end
`endif

   // bus FSM; the served register and dtack_r are loaded on entry to ACK so
   // the CPU sees dtack one cycle after data arrives
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         din_r     <= OPEN_BUS;
         dtack_r   <= 1'b1;
         srv_valid <= 1'b0;
         srv_addr  <= '0;
         req_addr  <= '0;
         rom_req   <= 1'b0;
         rom_addr  <= '0;
`ifdef JTKCPU_ROMLINE_EN
         use_line  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  req_addr <= cpu_addr;
                  dtack_r  <= 1'b0;
                  if (rom_cs) begin
`ifdef JTKCPU_ROMLINE_EN
                     if (line_hit) begin
                        use_line <= 1'b1;
                        state    <= RAM_RD;
                     end else begin
                        use_line <= 1'b0;
                        rom_req  <= 1'b1;
                        rom_addr <= cpu_addr[ROM_AW-1:2];
                        state    <= ROM_WAIT;
                     end
`else
                     rom_req  <= 1'b1;
                     rom_addr <= cpu_addr[ROM_AW-1:2];
                     state    <= ROM_WAIT;
`endif
                  end else begin
`ifdef JTKCPU_ROMLINE_EN
                     use_line <= 1'b0;
`endif
                     state <= RAM_RD;
                  end
               end
            end
            ROM_WAIT: begin
               if (rom_ok) begin
                  din_r     <= sel_byte(rom_data, req_addr[1:0]);
                  rom_req   <= 1'b0;
                  srv_addr  <= req_addr;
                  srv_valid <= 1'b1;
                  dtack_r   <= 1'b1;
                  state     <= ACK;
               end
            end
            RAM_RD: begin
`ifdef JTKCPU_ROMLINE_EN
               din_r <= use_line ? sel_byte(line_data, req_addr[1:0]) : ram_q;
`else
               din_r <= ram_q;
`endif
               srv_addr  <= req_addr;
               srv_valid <= 1'b1;
               dtack_r   <= 1'b1;
               state     <= ACK;
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (wr_srv) begin
            srv_valid <= 1'b0;
         end
      end
   end

endmodule
